// File: rtl/cond_pkg.sv
// Shared encodings for the condition unit: Cond field values,
// NZCV bit positions and FlagW bit meanings.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational condition evaluator: Cond field against NZCV.
// Unknown or unmatched Cond falls to the default and never executes.
module cond_check
    import cond_pkg::*;
#(
    parameter bit NV_EXECUTES = 1'b0
) (
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic n, z, c, v;

    assign n = Flags[FLAG_N];
    assign z = Flags[FLAG_Z];
    assign c = Flags[FLAG_C];
    assign v = Flags[FLAG_V];

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            COND_NV: CondEx = NV_EXECUTES;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/conditional_logic.sv
// NZCV flag register, condition evaluation and write-strobe gating
// between the control unit and the datapath.
module conditional_logic
    import cond_pkg::*;
#(
    parameter logic [3:0] FLAG_RESET  = 4'b0000,
    parameter bit         NV_EXECUTES = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       StepEn,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       CondEx,
    output logic       CondExReg,
    output logic [3:0] Flags,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite
);

    logic [1:0] flag_write;

    cond_check #(
        .NV_EXECUTES(NV_EXECUTES)
    ) u_check (
        .Cond  (Cond),
        .Flags (Flags),
        .CondEx(CondEx)
    );

    // A failing instruction must not update the flags it was tested on.
    assign flag_write = FlagW & {CondEx, CondEx};

    always_ff @(posedge clk) begin
        if (reset) begin
            Flags     <= FLAG_RESET;
            CondExReg <= 1'b0;
        end else if (StepEn) begin
            if (flag_write[FLAGW_NZ]) begin
                Flags[FLAG_N] <= ALUFlags[FLAG_N];
                Flags[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (flag_write[FLAGW_CV]) begin
                Flags[FLAG_C] <= ALUFlags[FLAG_C];
                Flags[FLAG_V] <= ALUFlags[FLAG_V];
            end
            CondExReg <= CondEx;
        end
    end

    assign PCSrc    = PCS & CondEx;
    assign RegWrite = RegW & CondEx & ~NoWrite;
    assign MemWrite = MemW & CondEx;

endmodule

// File: tb/tb_conditional_logic.sv
// Scoreboard bench for conditional_logic: directed plan items then
// randomized traffic against a behavioural NZCV model.
module tb_conditional_logic;

    localparam logic [3:0] FR  = 4'b0000;
    localparam bit         NVX = 1'b0;

    logic       clk = 1'b0;
    logic       reset, StepEn, PCS, RegW, MemW, NoWrite;
    logic [3:0] Cond, ALUFlags;
    logic [1:0] FlagW;
    logic       CondEx, CondExReg, PCSrc, RegWrite, MemWrite;
    logic [3:0] Flags;

    always #5 clk = ~clk;

    conditional_logic #(
        .FLAG_RESET (FR),
        .NV_EXECUTES(NVX)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .StepEn   (StepEn),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .RegW     (RegW),
        .MemW     (MemW),
        .NoWrite  (NoWrite),
        .CondEx   (CondEx),
        .CondExReg(CondExReg),
        .Flags    (Flags),
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite)
    );

    // {CondEx, PCSrc, RegWrite, MemWrite, Flags[3:0], CondExReg}
    logic [8:0] expq[$];
    string      tagq[$];
    int         passed = 0;
    int         total  = 0;

    bit [3:0] mflags;
    bit       mcer;

    // ARM rule: pairs share a base test, odd encodings invert it.
    function automatic bit cond_ok(input bit [3:0] c, input bit [3:0] f);
        bit n, z, cy, v, base;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        base = 1'b0;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        if (c == 4'hF)
            return NVX;
        return c[0] ? !base : base;
    endfunction

    task automatic step(input bit rst, input bit se, input bit [3:0] c,
                        input bit [3:0] af, input bit [1:0] fw,
                        input bit pcs, input bit rw, input bit mw,
                        input bit nw, input bit chk, input string tag);
        bit ce;
        reset    = rst;
        StepEn   = se;
        Cond     = c;
        ALUFlags = af;
        FlagW    = fw;
        PCS      = pcs;
        RegW     = rw;
        MemW     = mw;
        NoWrite  = nw;
        ce = cond_ok(c, mflags);
        if (chk) begin
            expq.push_back({ce, pcs & ce, rw & ce & ~nw, mw & ce,
                            mflags, mcer});
            tagq.push_back(tag);
        end
        @(posedge clk);
        if (rst) begin
            mflags = FR;
            mcer   = 1'b0;
        end else if (se) begin
            if (fw[1] && ce) mflags[3:2] = af[3:2];
            if (fw[0] && ce) mflags[1:0] = af[1:0];
            mcer = ce;
        end
        #1;
    endtask

    task automatic op(input bit [3:0] c, input bit [3:0] af,
                      input bit [1:0] fw, input string tag);
        step(0, 1, c, af, fw, 1, 1, 1, 0, 1, tag);
    endtask

    always @(negedge clk) begin
        logic [8:0] got, e;
        string t;
        if (expq.size() > 0) begin
            got = {CondEx, PCSrc, RegWrite, MemWrite, Flags, CondExReg};
            e = expq.pop_front();
            t = tagq.pop_front();
            total++;
            if (got === e)
                passed++;
            else
                $display("FAIL %s: got {ce,pc,rw,mw,nzcv,cer}=%b want %b",
                         t, got, e);
        end
    end

    initial begin
        reset = 1; StepEn = 1; Cond = 0; ALUFlags = 0; FlagW = 0;
        PCS = 0; RegW = 0; MemW = 0; NoWrite = 0;
        @(posedge clk);
        #1;
        step(1, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, "pre");
        step(1, 1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 0, "pre");

        step(0, 1, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0, 1, "reset_eq");
        step(0, 1, 4'hE, 4'h0, 2'b00, 0, 1, 0, 0, 1, "al_regw");
        op(4'hE, 4'b0100, 2'b11, "al_setz");
        op(4'h0, 4'h0, 2'b00, "eq_after_z");
        op(4'h1, 4'b1011, 2'b11, "ne_fail_blocks");
        op(4'hE, 4'h0, 2'b00, "flags_held");
        step(1, 1, 4'hE, 4'hF, 2'b11, 1, 1, 1, 0, 1, "reset_mid");
        op(4'hE, 4'hF, 2'b01, "part_cv");
        op(4'hE, 4'b1100, 2'b10, "part_nz");
        op(4'hE, 4'h0, 2'b00, "all_set");
        op(4'hE, 4'b1001, 2'b11, "set_1001");
        op(4'hA, 4'h0, 2'b00, "ge_1001");
        op(4'hB, 4'h0, 2'b00, "lt_1001");
        op(4'hC, 4'h0, 2'b00, "gt_1001");
        op(4'hD, 4'h0, 2'b00, "le_1001");
        op(4'hE, 4'b1000, 2'b11, "set_1000");
        op(4'hA, 4'h0, 2'b00, "ge_1000");
        op(4'hB, 4'h0, 2'b00, "lt_1000");
        op(4'hD, 4'h0, 2'b00, "le_1000");
        op(4'hE, 4'b0010, 2'b11, "set_0010");
        op(4'h8, 4'h0, 2'b00, "hi_0010");
        op(4'h9, 4'h0, 2'b00, "ls_0010");
        for (int i = 0; i < 3; i++)
            step(0, 0, 4'hE, 4'hF, 2'b11, 1, 1, 1, 0, 1, "stall");
        op(4'h0, 4'h0, 2'b00, "after_stall");
        step(0, 1, 4'hE, 4'h0, 2'b00, 1, 1, 1, 1, 1, "nowrite");
        op(4'hF, 4'hF, 2'b11, "nv");
        op(4'hE, 4'h0, 2'b00, "after_nv");

        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 19) == 0,
                 $urandom_range(0, 3) != 0,
                 4'($urandom), 4'($urandom), 2'($urandom),
                 1'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1, "rand");
        end

        reset = 0; StepEn = 0;
        for (int i = 0; i < 10 && expq.size() > 0; i++)
            @(posedge clk);
        if (expq.size() > 0) begin
            total++;
            $display("FAIL drain: %0d entries left, want 0", expq.size());
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
